// File: rtl/ahbl_gpio_irq.sv
// AHB-Lite GPIO controller with synchronised inputs, per-pin level/edge
// interrupts, sticky W1C edge status and atomic set/clear of the output register.
module ahbl_gpio_irq #(
  parameter int unsigned PINS        = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            HSEL,
  input  logic [23:2]     HADDR,
  input  logic            HREADY,
  input  logic            HWRITE,
  input  logic [1:0]      HTRANS,
  input  logic [2:0]      HSIZE,
  input  logic [31:0]     HWDATA,
  output logic [31:0]     HRDATA,
  output logic            HREADYOUT,
  output logic [1:0]      HRESP,
  input  logic [PINS-1:0] GPIO_IN,
  output logic [PINS-1:0] GPIO_OUT,
  output logic [PINS-1:0] GPIO_PU,
  output logic [PINS-1:0] GPIO_PD,
  output logic [PINS-1:0] GPIO_DIR,
  output logic [PINS-1:0] IRQ,
  output logic            IRQ_ANY
);

  localparam int unsigned      CW      = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0]    ARM_CNT = CW'(SYNC_STAGES + 1);

  typedef enum logic [3:0] {
    R_DIN  = 4'd0,  R_DOUT = 4'd1,  R_PU   = 4'd2,  R_PD   = 4'd3,
    R_DIR  = 4'd4,  R_IM   = 4'd5,  R_TYPE = 4'd6,  R_POL  = 4'd7,
    R_BOTH = 4'd8,  R_RIS  = 4'd9,  R_MIS  = 4'd10, R_ICR  = 4'd11,
    R_DSET = 4'd12, R_DCLR = 4'd13
  } reg_idx_e;

  logic [21:0]     addr_q;
  logic            write_q;
  logic            valid_q;
  logic            addr_ok;
  reg_idx_e        idx;
  logic            wr_en;
  logic [PINS-1:0] wd;

  logic [PINS-1:0] dout_q, pu_q, pd_q, dir_q, im_q, type_q, pol_q, both_q;
  logic [PINS-1:0] ris_q;

  logic [SYNC_STAGES-1:0][PINS-1:0] sync_q;
  logic [PINS-1:0] s, p_q;
  logic [CW-1:0]   arm_cnt;
  logic            armed;

  logic [PINS-1:0] rise, fall, hit, icr;
  logic [PINS-1:0] ris, mis;
  logic [PINS-1:0] rd_pins;
  logic            rd_bad;
  logic            unused_ok;

  assign HREADYOUT = 1'b1;
  assign HRESP     = 2'b00;
  assign unused_ok = ^{HSIZE, HTRANS[0], HWDATA};

  // Address phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (HSEL && HREADY) begin
      addr_q  <= HADDR;
      write_q <= HWRITE;
      valid_q <= HTRANS[1];
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign addr_ok = (addr_q[21:4] == '0) && (addr_q[3:0] <= 4'd13);
  assign idx     = reg_idx_e'(addr_q[3:0]);
  assign wr_en   = valid_q && write_q && addr_ok;
  assign wd      = HWDATA[PINS-1:0];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dout_q <= '0;
      pu_q   <= '0;
      pd_q   <= '0;
      dir_q  <= '0;
      im_q   <= '0;
      type_q <= '0;
      pol_q  <= '0;
      both_q <= '0;
    end else if (wr_en) begin
      case (idx)
        R_DOUT:  dout_q <= wd;
        R_PU:    pu_q   <= wd;
        R_PD:    pd_q   <= wd;
        R_DIR:   dir_q  <= wd;
        R_IM:    im_q   <= wd;
        R_TYPE:  type_q <= wd;
        R_POL:   pol_q  <= wd;
        R_BOTH:  both_q <= wd;
        R_DSET:  dout_q <= dout_q | wd;
        R_DCLR:  dout_q <= dout_q & ~wd;
        default: ;
      endcase
    end
  end

  // Input synchroniser, previous-sample flop and post-reset arming counter
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync_q  <= '0;
      p_q     <= '0;
      arm_cnt <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], GPIO_IN};
      p_q     <= s;
      if (!armed) arm_cnt <= arm_cnt + 1'b1;
    end
  end

  assign s     = sync_q[SYNC_STAGES-1];
  assign armed = (arm_cnt == ARM_CNT);
  assign rise  = s & ~p_q;
  assign fall  = ~s & p_q;
  assign hit   = armed ? (type_q & ((both_q & (rise | fall)) |
                                    (~both_q & ((pol_q & rise) | (~pol_q & fall)))))
                       : '0;
  assign icr   = (wr_en && idx == R_ICR) ? (wd & type_q) : '0;

  // Sticky edge status; a hit in the same cycle as its clear wins
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) ris_q <= '0;
    else          ris_q <= hit | (ris_q & ~icr);
  end

  // Level pins report the live synchronised level, so they bypass the sticky flop
  assign ris     = (type_q & ris_q) | (~type_q & ~(s ^ pol_q));
  assign mis     = ris & im_q & ~dir_q;
  assign IRQ     = mis;
  assign IRQ_ANY = |mis;

  assign GPIO_OUT = dout_q;
  assign GPIO_PU  = pu_q;
  assign GPIO_PD  = pd_q;
  assign GPIO_DIR = dir_q;

  always_comb begin
    rd_pins = '0;
    rd_bad  = 1'b0;
    if (!addr_ok) begin
      rd_bad = 1'b1;
    end else begin
      case (idx)
        R_DIN:   rd_pins = s;
        R_DOUT:  rd_pins = dout_q;
        R_PU:    rd_pins = pu_q;
        R_PD:    rd_pins = pd_q;
        R_DIR:   rd_pins = dir_q;
        R_IM:    rd_pins = im_q;
        R_TYPE:  rd_pins = type_q;
        R_POL:   rd_pins = pol_q;
        R_BOTH:  rd_pins = both_q;
        R_RIS:   rd_pins = ris;
        R_MIS:   rd_pins = mis;
        default: rd_pins = '0;
      endcase
    end
  end

  assign HRDATA = rd_bad ? 32'hDEADBEEF : 32'(rd_pins);

endmodule

// File: tb/tb_ahbl_gpio_irq.sv
// Directed bench for ahbl_gpio_irq: register map, set/clear, edge/level
// interrupts, W1C races and post-reset arming.
module tb_ahbl_gpio_irq;

  localparam int unsigned PINS = 16;
  localparam int unsigned SS   = 3;

  logic            HCLK = 1'b0;
  logic            HRESETn;
  logic            HSEL;
  logic [23:2]     HADDR;
  logic            HREADY;
  logic            HWRITE;
  logic [1:0]      HTRANS;
  logic [2:0]      HSIZE;
  logic [31:0]     HWDATA;
  logic [31:0]     HRDATA;
  logic            HREADYOUT;
  logic [1:0]      HRESP;
  logic [PINS-1:0] GPIO_IN;
  logic [PINS-1:0] GPIO_OUT, GPIO_PU, GPIO_PD, GPIO_DIR, IRQ;
  logic            IRQ_ANY;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  logic [31:0] rdat;

  ahbl_gpio_irq #(.PINS(PINS), .SYNC_STAGES(SS)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HREADY(HREADY), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .GPIO_IN(GPIO_IN), .GPIO_OUT(GPIO_OUT), .GPIO_PU(GPIO_PU),
    .GPIO_PD(GPIO_PD), .GPIO_DIR(GPIO_DIR), .IRQ(IRQ), .IRQ_ANY(IRQ_ANY)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int unsigned n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  task automatic wr(input int unsigned idx, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 22'(idx);
    ticks(1);
    bus_idle();
    HWDATA = d;
    ticks(1);
  endtask

  task automatic rd(input int unsigned idx, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 22'(idx);
    ticks(1);
    bus_idle();
    d = HRDATA;
  endtask

  // Write followed immediately by a read of the same register
  task automatic wr_rd(input int unsigned idx, input logic [31:0] d, output logic [31:0] q);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 22'(idx);
    ticks(1);
    HWRITE = 1'b0; HWDATA = d;
    ticks(1);
    bus_idle();
    q = HRDATA;
  endtask

  initial begin
    HRESETn = 1'b0; HREADY = 1'b1; HSIZE = 3'b010; HWDATA = '0; HADDR = '0;
    bus_idle();
    GPIO_IN = 16'hFFFF;
    ticks(3);
    check("rst_out",    {16'h0, GPIO_OUT}, 32'h0);
    check("rst_pu_pd",  {GPIO_PU, GPIO_PD}, 32'h0);
    check("rst_dir",    {16'h0, GPIO_DIR}, 32'h0);
    check("rst_irq",    {15'h0, IRQ_ANY, IRQ}, 32'h0);
    check("rst_hrdata", HRDATA, 32'h0);
    check("tied_ready_resp", {29'h0, HREADYOUT, HRESP}, 32'h4);
    HRESETn = 1'b1;
    ticks(6);

    // Register map sweep; high pins keep low-polarity level status clear
    for (int unsigned i = 0; i <= 14; i++) begin
      rd(i, rdat);
      check($sformatf("read_idx%0d", i), rdat,
            (i == 0) ? 32'h0000FFFF : (i == 14) ? 32'hDEADBEEF : 32'h0);
    end
    rd(32'h40, rdat);
    check("read_far_idx", rdat, 32'hDEADBEEF);

    // Output register with atomic set/clear
    wr(1, 32'h0000_00F0);
    wr(12, 32'h0000_0003);
    wr(13, 32'h0000_0010);
    check("gpio_out", {16'h0, GPIO_OUT}, 32'h00E3);
    rd(1, rdat);  check("dout_rb", rdat, 32'h00E3);
    rd(12, rdat); check("dset_rb", rdat, 32'h0);
    rd(13, rdat); check("dclr_rb", rdat, 32'h0);
    wr_rd(2, 32'hFFFF_1234, rdat);
    check("b2b_pu_rb", rdat, 32'h1234);
    check("gpio_pu", {16'h0, GPIO_PU}, 32'h1234);
    wr(3, 32'h0000_0055);
    check("gpio_pd", {16'h0, GPIO_PD}, 32'h0055);
    wr(14, 32'h1234_5678);
    check("bad_wr_ignored", {16'h0, GPIO_OUT}, 32'h00E3);

    // Rising edge on pin 3
    GPIO_IN[3] = 1'b0;
    ticks(SS + 2);
    wr(6, 32'h8); wr(7, 32'h8); wr(5, 32'h8); wr(4, 32'h0);
    GPIO_IN[3] = 1'b1;
    ticks(SS);
    check("p3_early", {15'h0, IRQ_ANY, IRQ}, 32'h0);
    ticks(1);
    check("p3_irq", {15'h0, IRQ_ANY, IRQ}, 32'h1_0008);
    rd(9, rdat); check("p3_ris", rdat, 32'h8);
    wr(11, 32'h8);
    check("p3_cleared", {15'h0, IRQ_ANY, IRQ}, 32'h0);

    // Both edges on pin 0 (POL low, so the rising edge only counts through BOTH)
    wr(8, 32'h1); wr(6, 32'h1); wr(7, 32'h0); wr(5, 32'h1); wr(11, 32'h1);
    GPIO_IN[0] = 1'b0;
    ticks(SS);
    check("p0_fall_early", {16'h0, IRQ}, 32'h0);
    ticks(1);
    check("p0_fall", {16'h0, IRQ}, 32'h1);
    wr(11, 32'h1);
    check("p0_icr", {16'h0, IRQ}, 32'h0);
    GPIO_IN[0] = 1'b1;
    ticks(SS + 1);
    check("p0_rise", {16'h0, IRQ}, 32'h1);
    wr(4, 32'h1);
    check("p0_dir_mask", {15'h0, IRQ_ANY, IRQ}, 32'h0);
    rd(9, rdat); check("p0_ris_kept", rdat, 32'h1);

    // Level-low on pin 5
    wr(4, 32'h0); wr(11, 32'h1); wr(6, 32'h0); wr(5, 32'h20);
    check("lvl_idle", {16'h0, IRQ}, 32'h0);
    GPIO_IN[5] = 1'b0;
    ticks(SS - 1);
    check("lvl_early", {16'h0, IRQ}, 32'h0);
    ticks(1);
    check("lvl_irq", {15'h0, IRQ_ANY, IRQ}, 32'h1_0020);
    wr(11, 32'h20);
    check("lvl_icr_noeffect", {16'h0, IRQ}, 32'h20);
    rd(9, rdat); check("lvl_ris", rdat, 32'h20);
    rd(10, rdat); check("lvl_mis", rdat, 32'h20);
    GPIO_IN[5] = 1'b1;
    ticks(SS - 1);
    check("lvl_hold", {16'h0, IRQ}, 32'h20);
    ticks(1);
    check("lvl_release", {16'h0, IRQ}, 32'h0);

    // Edge hit lands on the same edge as the ICR write
    wr(6, 32'h1); wr(5, 32'h1); wr(11, 32'h1);
    check("race_pre", {16'h0, IRQ}, 32'h0);
    GPIO_IN[0] = 1'b0;
    ticks(2);
    wr(11, 32'h1);
    check("race_set_wins", {16'h0, IRQ}, 32'h1);
    wr(11, 32'h1);
    check("race_cleared", {16'h0, IRQ}, 32'h0);

    // Re-reset with pin 7 high; configure rising edge on pin 7 as fast as the bus allows
    GPIO_IN = 16'hFFFF;
    HRESETn = 1'b0;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 22'd6;
    ticks(2);
    check("rst2_irq", {15'h0, IRQ_ANY, IRQ}, 32'h0);
    HRESETn = 1'b1;
    ticks(1);
    HADDR = 22'd7; HWDATA = 32'h80;
    ticks(1);
    HADDR = 22'd5; HWDATA = 32'h80;
    ticks(1);
    bus_idle(); HWDATA = 32'h80;
    ticks(1);
    check("arm_no_spurious", {15'h0, IRQ_ANY, IRQ}, 32'h0);
    ticks(3);
    check("arm_no_spurious_late", {16'h0, IRQ}, 32'h0);
    rd(9, rdat); check("arm_ris", rdat, 32'h0);
    rd(6, rdat); check("arm_type_rb", rdat, 32'h80);
    GPIO_IN[7] = 1'b0;
    ticks(SS + 2);
    check("arm_fall_ignored", {16'h0, IRQ}, 32'h0);
    GPIO_IN[7] = 1'b1;
    ticks(SS + 1);
    check("arm_rise_seen", {15'h0, IRQ_ANY, IRQ}, 32'h1_0080);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ahbl_gpio_irq.md
# ahbl_gpio_irq

Parametrised AHB-Lite GPIO controller: PINS-wide output, pull-up, pull-down and direction registers, plus a synchronised input path. Adds per-pin interrupt generation (level or edge, selectable polarity or both edges), sticky write-1-to-clear status, and atomic set/clear of the output register. Sits on the AHB-Lite system bus as a zero-wait-state slave. Drives per-pin and combined interrupt lines to the interrupt controller.

## Interface
- PINS, 16, number of GPIO pins (1..32); register bits above PINS-1 read 0 and ignore writes
- SYNC_STAGES, 2, input synchroniser depth (2..3)
- HCLK  in  1  bus clock; sole clock
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  slave select
- HADDR  in  [23:2]  word address
- HREADY  in  1  bus ready
- HWRITE  in  1  write control
- HTRANS  in  2  transfer type; only bit 1 is used
- HSIZE  in  3  transfer size; ignored, every write is full-word
- HWDATA  in  32  write data
- HRDATA  out  32  read data
- HREADYOUT  out  1  tied 1
- HRESP  out  2  tied 2'b00
- GPIO_IN  in  PINS  asynchronous pad inputs
- GPIO_OUT  out  PINS  output data register
- GPIO_PU  out  PINS  pull-up enables
- GPIO_PD  out  PINS  pull-down enables
- GPIO_DIR  out  PINS  1 = output
- IRQ  out  PINS  masked per-pin interrupt (MIS)
- IRQ_ANY  out  1  OR of MIS

## Operation
- Register map, word index HADDR[23:2]:
  - 0 DIN (RO, synchronised)
  - 1 DOUT
  - 2 PU
  - 3 PD
  - 4 DIR
  - 5 IM (mask)
  - 6 TYPE (1 = edge, 0 = level)
  - 7 POL (1 = high/rising, 0 = low/falling)
  - 8 BOTH (1 = both edges; overrides POL in edge mode)
  - 9 RIS (RO)
  - 10 MIS (RO)
  - 11 ICR (WO, write 1 to clear)
  - 12 DSET (WO, DOUT |= wdata)
  - 13 DCLR (WO, DOUT &= ~wdata)
- Reads of WO registers return 0. Any other index reads 32'hDEADBEEF; writes to it are ignored.
- Synchroniser: SYNC_STAGES flops per pin, output `s`. A further flop `p` holds the previous `s`.
- Edge detect:
  - rise = s & ~p
  - fall = ~s & p
  - hit = BOTH ? (rise | fall) : (POL ? rise : fall)
- RIS, edge pins: sticky. Set on hit; cleared by an ICR write of 1. If set and clear occur in the same cycle, set wins.
- RIS, level pins: not sticky. RIS = (s == POL) each cycle. ICR has no effect.
- MIS = RIS & IM & ~DIR. IRQ = MIS. IRQ_ANY = |MIS. Both are combinational from flops.
- Changing TYPE, POL or BOTH does not clear stored edge status.
- Arming counter:
  - After reset, a counter of ceil(log2(SYNC_STAGES+2)) bits counts to SYNC_STAGES+1.
  - Edge hits are suppressed until the count is reached, so pins held high at reset raise no spurious edge.
  - Level status is not gated by the counter.
- Reset values:
  - All registers, synchroniser flops, p, RIS and counter = 0.
  - GPIO_OUT/PU/PD/DIR = 0, IRQ = 0, IRQ_ANY = 0.
  - HRDATA = DIN = 0, since the index register resets to 0.

## Timing
- Address phase: when HSEL & HREADY, register address, HWRITE and HTRANS[1]; otherwise the stored valid bit is cleared.
- Writes: applied at the rising edge that ends the data phase, using HWDATA. The new value is visible on outputs and reads the next cycle.
- Back-to-back write then read of the same register returns the new value.
- Reads: HRDATA is combinational from the registered index and register state. Zero wait states.
- Input latency:
  - A pin change appears in DIN after SYNC_STAGES HCLK edges.
  - An edge sets RIS one edge later (SYNC_STAGES+1 edges after the change); IRQ follows in the same cycle.
- Level IRQ deasserts SYNC_STAGES edges after the pin leaves the active level.
- Asynchronous reset mid-transfer: the transfer is abandoned and all state returns to reset values immediately.
- Edge detection re-arms SYNC_STAGES+1 edges after reset release.

## Test plan
- Reset, then read indices 0..13 and 14 → DIN = pin value after sync; 0 for registers 1..13; 32'hDEADBEEF for index 14. All outputs 0.
- Write DOUT = 0x00F0, DSET = 0x0003, DCLR = 0x0010 → GPIO_OUT = 0x00E3, readback 0x00E3. Reads of DSET/DCLR return 0.
- Rising-edge interrupt on pin 3:
  - Setup: TYPE = 0x8, POL = 0x8, IM = 0x8, DIR = 0. Drive GPIO_IN[3] 0→1.
  - RIS[3] = 1 and IRQ[3] = IRQ_ANY = 1 exactly SYNC_STAGES+1 edges after the change.
  - Write ICR = 0x8 → both drop the next cycle.
- BOTH = 0x1, TYPE = 0x1, IM = 0x1: toggle pin 0 with ICR writes between toggles → each toggle sets RIS[0]. Set DIR[0] = 1 → IRQ[0] = 0 while RIS[0] stays 1.
- Level low on pin 5 (TYPE[5] = 0, POL[5] = 0, IM[5] = 1), pin held 0:
  - RIS[5] = 1; an ICR write has no effect.
  - Drive the pin to 1 → IRQ[5] = 0 after SYNC_STAGES edges.
- Simultaneous edge hit and ICR write on the same cycle → RIS stays 1.
- Reset released with pin 7 held 1 and TYPE/POL set for rising → no RIS[7] set.
